// File: rtl/sram_mem_ctrl.sv
// Multi-cycle data-memory controller: splits each CPU word into narrow SRAM
// beats with configurable wait states and freezes the pipeline via ready.
module sram_mem_ctrl #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          SRAM_DW     = 16,
   parameter int          SRAM_AW     = 18,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [31:0]           address,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  ready,
   output logic [SRAM_AW-1:0]    sram_addr,
   output logic [SRAM_DW-1:0]    sram_dq_out,
   output logic                  sram_dq_oe,
   input  logic [SRAM_DW-1:0]    sram_dq_in,
   output logic                  sram_we_n
);

   localparam int BEATS = DATA_WIDTH / SRAM_DW;
   localparam int CPB   = WAIT_CYCLES + 1;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WW    = (CPB > 1) ? $clog2(CPB) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state, state_nxt;
   logic [BW-1:0]         beat_cnt;
   logic [WW-1:0]         wait_cnt;
   logic                  is_wr;
   logic [DATA_WIDTH-1:0] wr_sh;
   logic [31:0]           word;
   logic [31:0]           first_idx;
   logic                  last_wait, last_beat, req;

   assign req       = rd_en | wr_en;
   assign word      = (address - BASE_ADDR) >> 2;
   assign first_idx = word * 32'(BEATS);
   assign last_wait = (wait_cnt == WW'(CPB - 1));
   assign last_beat = (beat_cnt == BW'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         IDLE: begin
            ready = ~req;
            if (req) state_nxt = ACCESS;
         end
         ACCESS: if (last_wait && last_beat) state_nxt = DONE;
         DONE: begin
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pad-facing outputs are registered, so each beat is set up on the edge
   // that enters it and holds for all CPB cycles of that beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt    <= '0;
         wait_cnt    <= '0;
         is_wr       <= 1'b0;
         wr_sh       <= '0;
         rd_data     <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  is_wr     <= wr_en;
                  beat_cnt  <= '0;
                  wait_cnt  <= '0;
                  sram_addr <= SRAM_AW'(first_idx);
                  if (wr_en) begin
                     sram_dq_out <= wr_data[SRAM_DW-1:0];
                     wr_sh       <= wr_data >> SRAM_DW;
                     sram_dq_oe  <= 1'b1;
                     sram_we_n   <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (!is_wr && last_wait)
                  rd_data[int'(beat_cnt)*SRAM_DW +: SRAM_DW] <= sram_dq_in;
               if (last_wait) begin
                  wait_cnt <= '0;
                  if (last_beat) begin
                     beat_cnt   <= '0;
                     sram_dq_oe <= 1'b0;
                     sram_we_n  <= 1'b1;
                  end else begin
                     beat_cnt  <= beat_cnt + 1'b1;
                     sram_addr <= sram_addr + 1'b1;
                     if (is_wr) begin
                        sram_dq_out <= wr_sh[SRAM_DW-1:0];
                        wr_sh       <= wr_sh >> SRAM_DW;
                     end
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               sram_dq_oe <= 1'b0;
               sram_we_n  <= 1'b1;
            end
         endcase
      end
   end

endmodule
